// File: rtl/axi4_slave_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi4_slave_mem_responder
// Description : Parametrised AXI4 slave memory with FIXED/INCR/WRAP bursts,
//               SLVERR signalling and independent single-outstanding channels.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_slave_mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);
    localparam int c_BYTES = DATA_W / 8;
    localparam int c_SHIFT = $clog2(c_BYTES);
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
        logic [ADDR_W-1:0] incr;
        logic [ADDR_W-1:0] mask;
        incr = addr + ADDR_W'(c_BYTES);
        mask = (ADDR_W'(len) + ADDR_W'(1)) * ADDR_W'(c_BYTES) - ADDR_W'(1);
        if (burst == 2'd0)
            return addr;
        if (burst == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            return (addr & ~mask) | (incr & mask);
        return incr;
    endfunction

    function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
        return (addr >> c_SHIFT) < ADDR_W'(DEPTH);
    endfunction

    function automatic logic [c_IDX_W-1:0] f_index(input logic [ADDR_W-1:0] addr);
        return c_IDX_W'(addr >> c_SHIFT);
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];

    // ---------------- write channel ----------------
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    w_state_t          r_w_state, w_w_state_nxt;
    logic [ID_W-1:0]   r_aw_id;
    logic [ADDR_W-1:0] r_aw_addr;
    logic [7:0]        r_aw_len;
    logic [1:0]        r_aw_burst;
    logic [7:0]        r_w_cnt;
    logic              r_w_err;
    logic [1:0]        r_bresp;
    logic              w_aw_fire, w_w_fire, w_w_final, w_w_beat_err;

    always_comb begin
        w_w_state_nxt = r_w_state;
        w_aw_fire     = 1'b0;
        w_w_fire      = 1'b0;
        w_w_final     = (r_w_cnt == r_aw_len);
        w_w_beat_err  = !f_in_range(r_aw_addr) || (wlast != w_w_final);
        case (r_w_state)
            W_IDLE: if (awvalid) begin
                w_aw_fire     = 1'b1;
                w_w_state_nxt = W_DATA;
            end
            W_DATA: if (wvalid) begin
                w_w_fire = 1'b1;
                if (w_w_final)
                    w_w_state_nxt = W_RESP;
            end
            W_RESP: if (bready)
                w_w_state_nxt = W_IDLE;
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_w_state <= W_IDLE;
        else
            r_w_state <= w_w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_aw_id    <= '0;
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_burst <= '0;
            r_w_cnt    <= '0;
            r_w_err    <= 1'b0;
            r_bresp    <= 2'b00;
        end else begin
            if (w_aw_fire) begin
                r_aw_id    <= awid;
                r_aw_addr  <= awaddr;
                r_aw_len   <= awlen;
                r_aw_burst <= awburst;
                r_w_cnt    <= '0;
                r_w_err    <= 1'b0;
            end
            if (w_w_fire) begin
                r_w_err <= r_w_err | w_w_beat_err;
                if (w_w_final) begin
                    r_bresp <= (r_w_err | w_w_beat_err) ? 2'b10 : 2'b00;
                end else begin
                    r_aw_addr <= f_next_addr(r_aw_addr, r_aw_len, r_aw_burst);
                    r_w_cnt   <= r_w_cnt + 8'd1;
                end
            end
        end
    end

    // Out-of-range beats are dropped here; reset suppresses a beat in flight.
    always_ff @(posedge clock) begin
        if (w_w_fire && !reset && f_in_range(r_aw_addr)) begin
            for (int i = 0; i < c_BYTES; i++) begin
                if (wstrb[i])
                    r_mem[f_index(r_aw_addr)][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;
    r_state_t          r_r_state, w_r_state_nxt;
    logic [ID_W-1:0]   r_ar_id;
    logic [ADDR_W-1:0] r_ar_addr;
    logic [7:0]        r_ar_len;
    logic [1:0]        r_ar_burst;
    logic [7:0]        r_r_cnt;
    logic [c_LAT_W-1:0] r_lat_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rlast;
    logic              w_ar_fire, w_r_load;
    logic [ADDR_W-1:0] w_r_load_addr;
    logic [7:0]        w_r_load_cnt;

    // A beat is fetched either when the latency count expires or when the
    // current beat is accepted, so back-to-back beats never leave a bubble.
    always_comb begin
        w_r_state_nxt = r_r_state;
        w_ar_fire     = 1'b0;
        w_r_load      = 1'b0;
        w_r_load_addr = r_ar_addr;
        w_r_load_cnt  = r_r_cnt;
        case (r_r_state)
            R_IDLE: if (arvalid) begin
                w_ar_fire     = 1'b1;
                w_r_state_nxt = R_WAIT;
            end
            R_WAIT: if (r_lat_cnt == '0) begin
                w_r_load      = 1'b1;
                w_r_state_nxt = R_DATA;
            end
            R_DATA: if (rready) begin
                if (r_rlast) begin
                    w_r_state_nxt = R_IDLE;
                end else begin
                    w_r_load      = 1'b1;
                    w_r_load_addr = f_next_addr(r_ar_addr, r_ar_len, r_ar_burst);
                    w_r_load_cnt  = r_r_cnt + 8'd1;
                end
            end
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_r_state <= R_IDLE;
        else
            r_r_state <= w_r_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ar_id    <= '0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_burst <= '0;
            r_r_cnt    <= '0;
            r_lat_cnt  <= '0;
            r_rdata    <= '0;
            r_rresp    <= 2'b00;
            r_rlast    <= 1'b0;
        end else begin
            if (w_ar_fire) begin
                r_ar_id    <= arid;
                r_ar_addr  <= araddr;
                r_ar_len   <= arlen;
                r_ar_burst <= arburst;
                r_r_cnt    <= '0;
                r_lat_cnt  <= c_LAT_W'(RD_LAT - 1);
            end else if (r_r_state == R_WAIT && r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
            end
            if (w_r_load) begin
                r_ar_addr <= w_r_load_addr;
                r_r_cnt   <= w_r_load_cnt;
                r_rlast   <= (w_r_load_cnt == r_ar_len);
                if (f_in_range(w_r_load_addr)) begin
                    r_rdata <= r_mem[f_index(w_r_load_addr)];
                    r_rresp <= 2'b00;
                end else begin
                    r_rdata <= '0;
                    r_rresp <= 2'b10;
                end
            end
        end
    end

    assign awready = (r_w_state == W_IDLE) && !reset;
    assign wready  = (r_w_state == W_DATA);
    assign bvalid  = (r_w_state == W_RESP);
    assign bid     = r_aw_id;
    assign bresp   = r_bresp;
    assign arready = (r_r_state == R_IDLE) && !reset;
    assign rvalid  = (r_r_state == R_DATA);
    assign rid     = r_ar_id;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;

endmodule
`default_nettype wire

// File: doc/axi4_slave_mem_responder.md
Name: axi4_slave_mem_responder

Overview: Synthesizable, parametrised AXI4 slave memory responder for the AXI4_SLAVE agent's HDL side, used as a drop-in emulation-friendly target behind the FIFO_AXI DUT. Generalises the fixed single-beat responder: configurable data, address and ID widths, memory depth, and read latency, with FIXED/INCR/WRAP bursts and SLVERR signalling. Write and read channels run independently, each with one outstanding transaction.

Parameters:
- DATA_W, 32, data bus width in bits (power of 2, >=8); beat size is always DATA_W/8 bytes, so no AxSIZE ports.
- ADDR_W, 16, byte address width.
- ID_W, 4, transaction ID width.
- DEPTH, 256, memory depth in DATA_W words.
- RD_LAT, 2, cycles from AR handshake to first RVALID (>=1).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- awid/awaddr/awlen/awburst/awvalid  in  ID_W/ADDR_W/8/2/1  write address channel
- awready  out  1  write address accept
- wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data channel
- wready  out  1  write data accept
- bid/bresp/bvalid  out  ID_W/2/1  write response
- bready  in  1  write response accept
- arid/araddr/arlen/arburst/arvalid  in  ID_W/ADDR_W/8/2/1  read address channel
- arready  out  1  read address accept
- rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read data channel
- rready  in  1  read data accept

Behaviour:
- Interface: one clock, `clock`; reset `reset` is synchronous and active-high.
- Reset: all outputs 0, both FSMs go to IDLE. Memory array is not reset. Reset mid-burst aborts with no B/R issued. awready and arready are 1 on the first cycle after reset deasserts.
- Handshake: transfer when valid && ready on a rising clock edge. Once asserted, an output VALID holds, with its payload stable, until accepted.
- Word index = addr >> log2(DATA_W/8). A beat is in range iff index < DEPTH.
- Next beat address: FIXED(0) holds the address. INCR(1) adds DATA_W/8. WRAP(2) adds DATA_W/8 within a (len+1)*DATA_W/8-aligned window; WRAP is legal only for len in {1,3,7,15}, and other lens are treated as INCR. Burst 3 is treated as INCR. 4KB crossing is not checked.
- Write FSM: W_IDLE (awready=1) -> on AW handshake, latch id/addr/len/burst and clear the error flag -> W_DATA (wready=1; each beat writes the bytes where wstrb[i]=1, in-range only; the final beat is decided by the beat counter == awlen) -> W_RESP (bvalid=1, bid=latched id) -> on bready, W_IDLE. AW-to-first-wready latency is 1 cycle. bvalid asserts the cycle after the last W beat.
- bresp: 2'b10 (SLVERR) if any beat was out of range or wlast mismatched the counter (early or missing). Otherwise 2'b00. On mismatch the burst still ends on the counter.
- Read FSM: R_IDLE (arready=1) -> on AR handshake, latch fields -> R_WAIT, counting RD_LAT-1 cycles (0 for RD_LAT=1) -> R_DATA (rvalid=1; rdata = mem[index], registered; rlast when beat == arlen; rresp = SLVERR with rdata=0 for out-of-range beats, else OKAY) -> advance on rready -> R_IDLE after the rlast handshake.
- rvalid is continuous across beats when rready is held high: one beat per cycle, no bubbles.
- Same-cycle write and read to one word: the read returns the pre-write value.
- Write and read FSMs are fully concurrent. No ordering exists between channels.

Test Plan:
- Reset then INCR write: awaddr=0x10, awlen=3, data 0xA0..0xA3, wstrb=0xF; read back arlen=3 -> rdata A0,A1,A2,A3, rlast on beat 3, bresp=0, rresp=0, and first rvalid exactly 2 cycles after the AR handshake.
- WRAP read: araddr=0x38, arlen=3, DATA_W=32 -> word indices 14,15,12,13.
- FIXED write: awaddr=0x20, awlen=2, data 1,2,3 -> read of 0x20 returns 3.
- Byte strobes: write 0xFFFFFFFF, then 0x00000000 with wstrb=0x5 -> read returns 0xFF00FF00.
- Out of range: awaddr=DEPTH*4-4, awlen=1 -> bresp=2'b10 and in-range word written. Read of the same range -> beat0 OKAY, beat1 SLVERR with rdata=0. Early wlast on beat 0 of awlen=1 -> bresp=2'b10.
- Backpressure and reset: bready low for 5 cycles -> bvalid and bid held. rready toggling -> no lost or duplicated beats. Assert reset mid read burst -> rvalid=0 on the next cycle and arready=1 on the first cycle after reset deasserts.
